// File: rtl/fromrec_fn.sv
// Recoded-float to IEEE-754 binary32 decoder. Normals and specials finish in one
// cycle; subnormals are denormalised by a one-bit-per-cycle right shifter.
module fromrec_fn #(
    parameter int FP_BITS     = 32,
    parameter int EXP_BITS    = 8,
    parameter int FRA_BITS    = 23,
    parameter int SIG_BITS    = 24,
    parameter int RECEXP_BITS = 9,
    parameter logic [RECEXP_BITS-1:0] EXP_OFFSET = 9'b1_0000_0001
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign,
    input  logic [RECEXP_BITS-1:0] exp,
    input  logic [SIG_BITS-1:0]    sig,
    input  logic                   isNAN,
    input  logic                   isINf,
    input  logic                   isZero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FP_BITS-1:0]     fp,
    output logic                   out_inv
);

    localparam int CNT_BITS = 5;
    localparam logic [FRA_BITS-1:0] QNAN_FRAC  = {1'b1, {(FRA_BITS-1){1'b0}}};
    localparam logic [EXP_BITS-1:0] EXP_ALL1   = '1;
    localparam logic [FP_BITS-1:0]  CANON_QNAN = {1'b0, EXP_ALL1, QNAN_FRAC};
    localparam logic signed [RECEXP_BITS-1:0] D_NORM_MIN = 9'sd1;
    localparam logic signed [RECEXP_BITS-1:0] D_NORM_MAX = 9'sd254;
    localparam logic signed [RECEXP_BITS-1:0] D_SUB_MIN  = -9'sd22;
    localparam logic signed [RECEXP_BITS-1:0] D_SUB_MAX  = 9'sd0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OUT
    } state_t;

    state_t                state_reg, state_next;
    logic                  valid_reg, valid_next;
    logic [FP_BITS-1:0]    fp_reg, fp_next;
    logic                  inv_reg, inv_next;
    logic [CNT_BITS-1:0]   count_reg, count_next;
    logic [SIG_BITS-1:0]   shift_reg, shift_next;
    logic                  sign_reg, sign_next;

    // Unbiased exponent, 9-bit wrap-around, interpreted as signed
    logic [RECEXP_BITS-1:0] exp_diff;
    logic                   is_normal;
    logic                   is_subnormal;
    logic [FRA_BITS-1:0]    nan_frac;
    logic [FP_BITS-1:0]     fp_dec;
    logic                   inv_dec;
    logic                   shift_dec;

    assign exp_diff     = exp - EXP_OFFSET;
    assign is_normal    = ($signed(exp_diff) >= D_NORM_MIN) && ($signed(exp_diff) <= D_NORM_MAX);
    assign is_subnormal = ($signed(exp_diff) >= D_SUB_MIN) && ($signed(exp_diff) <= D_SUB_MAX);
    // A NaN with an all-zero payload would read back as infinity, so quieten it
    assign nan_frac     = (sig[FRA_BITS-1:0] == '0) ? QNAN_FRAC : sig[FRA_BITS-1:0];

    // Single-cycle classification of the operand currently on the input
    always_comb begin
        fp_dec    = '0;
        inv_dec   = 1'b0;
        shift_dec = 1'b0;
        if (isNAN) begin
            fp_dec = {sign, EXP_ALL1, nan_frac};
        end else if (isINf) begin
            fp_dec = {sign, EXP_ALL1, {FRA_BITS{1'b0}}};
        end else if (isZero) begin
            fp_dec = {sign, {(FP_BITS-1){1'b0}}};
        end else if (is_normal) begin
            fp_dec = {sign, exp_diff[EXP_BITS-1:0], sig[FRA_BITS-1:0]};
        end else if (is_subnormal) begin
            shift_dec = 1'b1;
        end else begin
            fp_dec  = CANON_QNAN;
            inv_dec = 1'b1;
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = valid_reg;
    assign fp        = fp_reg;
    assign out_inv   = inv_reg;

    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        fp_next    = fp_reg;
        inv_next   = inv_reg;
        count_next = count_reg;
        shift_next = shift_reg;
        sign_next  = sign_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (shift_dec) begin
                        shift_next = sig;
                        sign_next  = sign;
                        // 1 - d, d in -22..0, so the count is 1..23
                        count_next = CNT_BITS'(1) - exp_diff[CNT_BITS-1:0];
                        state_next = SHIFT;
                    end else begin
                        fp_next    = fp_dec;
                        inv_next   = inv_dec;
                        valid_next = 1'b1;
                        state_next = OUT;
                    end
                end
            end
            SHIFT: begin
                shift_next = shift_reg >> 1;
                count_next = count_reg - CNT_BITS'(1);
                if (count_reg <= CNT_BITS'(1)) begin
                    // The bits landing in the fraction are the ones just shifted down
                    fp_next    = {sign_reg, {EXP_BITS{1'b0}}, shift_reg[SIG_BITS-1:1]};
                    inv_next   = 1'b0;
                    valid_next = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            fp_reg    <= '0;
            inv_reg   <= 1'b0;
            count_reg <= '0;
            shift_reg <= '0;
            sign_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            fp_reg    <= fp_next;
            inv_reg   <= inv_next;
            count_reg <= count_next;
            shift_reg <= shift_next;
            sign_reg  <= sign_next;
        end
    end

endmodule

// File: tb/tb_fromrec_fn.sv
// Directed bench for fromrec_fn: a value-level decode model feeds a scoreboard
// that is checked against the DUT on every falling edge.
module tb_fromrec_fn;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        rec_sign;
    logic [8:0]  rec_exp;
    logic [23:0] rec_sig;
    logic        f_nan, f_inf, f_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp;
    logic        out_inv;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fromrec_fn dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign(rec_sign), .exp(rec_exp), .sig(rec_sig),
        .isNAN(f_nan), .isINf(f_inf), .isZero(f_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .fp(fp), .out_inv(out_inv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        s;
        logic [8:0]  e;
        logic [23:0] m;
        logic        nan, inf, zero;
        logic [31:0] efp;
        logic        einv;
        int          en;
    } vec_t;

    typedef struct {
        logic [31:0] fp;
        logic        inv;
        int          n;
        int          acc;
        bit          seen;
    } exp_t;

    exp_t q[$];
    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Decode by value: unbiased exponent as a plain integer, then classify
    function automatic void model(input vec_t v, output logic [31:0] f,
                                  output logic inv, output int n);
        int d;
        n   = 0;
        inv = 1'b0;
        if (v.nan)       f = {v.s, 8'hFF, (v.m[22:0] == 23'h0) ? 23'h400000 : v.m[22:0]};
        else if (v.inf)  f = {v.s, 8'hFF, 23'h0};
        else if (v.zero) f = {v.s, 31'h0};
        else begin
            d = int'(v.e) - 257;
            if (d < -256) d += 512;
            if (d >= 1 && d <= 254) f = {v.s, 8'(d), v.m[22:0]};
            else if (d >= -22 && d <= 0) begin
                n = 1 - d;
                f = {v.s, 8'h00, 23'(v.m >> n)};
            end else begin
                f   = 32'h7FC00000;
                inv = 1'b1;
            end
        end
    endfunction

    function automatic vec_t mk(input logic s, input logic [8:0] e, input logic [23:0] m,
                                input logic nan, input logic inf, input logic zero,
                                input logic [31:0] efp, input logic einv, input int en);
        vec_t v;
        v.s = s; v.e = e; v.m = m; v.nan = nan; v.inf = inf; v.zero = zero;
        v.efp = efp; v.einv = einv; v.en = en;
        return v;
    endfunction

    // Present one operand and record its expected result at the accepting edge
    task automatic send(input vec_t v);
        int   g = 0;
        exp_t x;
        rec_sign = v.s; rec_exp = v.e; rec_sig = v.m;
        f_nan = v.nan; f_inf = v.inf; f_zero = v.zero;
        in_valid = 1'b1;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model(v, x.fp, x.inv, x.n);
        x.acc  = cyc;
        x.seen = 1'b0;
        q.push_back(x);
        in_valid = 1'b0;
        rec_sign = 1'($urandom); rec_exp = 9'($urandom); rec_sig = 24'($urandom);
        f_nan = 1'($urandom); f_inf = 1'($urandom); f_zero = 1'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        end else if (q.size() == 0) begin
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_in_ready", 32'(in_ready), 32'd1);
        end else begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            if (out_valid) begin
                if (!q[0].seen) begin
                    q[0].seen = 1'b1;
                    chk("latency", 32'(cyc + 1 - q[0].acc), 32'(q[0].n + 1));
                end
                chk("fp", fp, q[0].fp);
                chk("out_inv", 32'(out_inv), 32'(q[0].inv));
                if (out_ready) void'(q.pop_front());
            end else if (q[0].seen) begin
                chk("out_valid_hold", 32'(out_valid), 32'd1);
                void'(q.pop_front());
            end else if (cyc - q[0].acc > q[0].n + 4) begin
                chk("result_timeout", 32'(out_valid), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] mf;
        logic        mi;
        int          mn;
        int          g;

        vecs[0]  = mk(0, 9'h180, 24'h800000, 0, 0, 0, 32'h3F800000, 0, 0);
        vecs[1]  = mk(1, 9'h17F, 24'hC00000, 0, 0, 0, 32'hBF400000, 0, 0);
        vecs[2]  = mk(0, 9'h0EB, 24'h800000, 0, 0, 0, 32'h00000001, 0, 23);
        vecs[3]  = mk(0, 9'h101, 24'h800000, 0, 0, 0, 32'h00400000, 0, 1);
        vecs[4]  = mk(1, 9'h180, 24'h800000, 0, 1, 0, 32'hFF800000, 0, 0);
        vecs[5]  = mk(1, 9'h180, 24'h800000, 0, 0, 1, 32'h80000000, 0, 0);
        vecs[6]  = mk(0, 9'h180, 24'hC00001, 1, 0, 0, 32'h7FC00001, 0, 0);
        vecs[7]  = mk(0, 9'h180, 24'h800000, 1, 0, 0, 32'h7FC00000, 0, 0);
        vecs[8]  = mk(1, 9'h180, 24'hA00000, 1, 0, 1, 32'hFFA00000, 0, 0);
        vecs[9]  = mk(0, 9'h000, 24'h800000, 0, 0, 0, 32'h7FC00000, 1, 0);
        vecs[10] = mk(0, 9'h0EA, 24'h800000, 0, 0, 0, 32'h7FC00000, 1, 0);
        vecs[11] = mk(1, 9'h0F0, 24'hABCDEF, 0, 0, 0, 32'h8000002A, 0, 18);
        vecs[12] = mk(0, 9'h1FF, 24'hFFFFFF, 0, 0, 0, 32'h7F7FFFFF, 0, 0);
        vecs[13] = mk(0, 9'h102, 24'h800000, 0, 0, 0, 32'h00800000, 0, 0);
        vecs[14] = mk(0, 9'h100, 24'h800000, 0, 0, 0, 32'h00200000, 0, 2);

        // Operand offered during reset must be discarded
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        rec_sign = 0; rec_exp = 9'h180; rec_sig = 24'h800000;
        f_nan = 0; f_inf = 0; f_zero = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_fp", fp, 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_inv", 32'(out_inv), 32'd0);
        rst = 1'b0; in_valid = 1'b0;

        foreach (vecs[i]) begin
            model(vecs[i], mf, mi, mn);
            chk($sformatf("model_fp[%0d]", i), mf, vecs[i].efp);
            chk($sformatf("model_inv[%0d]", i), 32'(mi), 32'(vecs[i].einv));
            chk($sformatf("model_shift[%0d]", i), 32'(mn), 32'(vecs[i].en));
        end

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) send(vecs[i]);
        drain();

        // Backpressure: hold the result for five cycles, then release
        foreach (vecs[i]) begin
            if (i == 0 || i == 11) begin
                out_ready = 1'b0;
                send(vecs[i]);
                g = 0;
                while (!out_valid && g < 40) begin
                    @(posedge clk); #1;
                    g++;
                end
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
                drain();
            end
        end

        // Reset during the fifth shift cycle of the longest subnormal
        send(vecs[2]);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        send(vecs[1]);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
